fifo_read_ctrl: RTL and testbench

Read-side controller for the synchronous FIFO. It owns the read pointer, derives the empty, almost-empty and occupancy flags by comparing against the write-side pointer, and pops words from the FIFO storage array into a registered output. It sits between the storage array, which is written by the write-side controller and read combinationally at `read_pointer`, and the downstream consumer. Everything is in the single `clk` domain.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_rd_flags.sv | 17 +
 rtl/fifo_read_ctrl.sv | 75 +++++++
 tb/tb_fifo_read_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer width, depth sanity check and pointer type shared by the FIFO read and write controllers
package fifo_pkg;
    localparam int FIFO_W_ADDRESS = 4;
    localparam int FIFO_PTR_W = FIFO_W_ADDRESS + 1;
    localparam int FIFO_L = 16;
    localparam bit FIFO_DEPTH_OK = (FIFO_L == (1 << FIFO_W_ADDRESS));
    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;
    function automatic bit depth_ok(input int aw, input int depth);
        return depth == (1 << aw);
    endfunction
endpackage

// File: rtl/fifo_rd_flags.sv
// fifo_rd_flags: occupancy, empty and almost-empty derived from the read and write pointers
module fifo_rd_flags #(
    parameter int w_address = 4,
    parameter int AE_THRESH = 2
) (
    input  logic [w_address:0] read_pointer,
    input  logic [w_address:0] write_pointer,
    output logic [w_address:0] rd_count,
    output logic               empty,
    output logic               almost_empty
);
    always_comb begin
        rd_count = write_pointer - read_pointer;
        empty = write_pointer == read_pointer;
        almost_empty = rd_count <= (w_address+1)'(AE_THRESH);
    end
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: FIFO read pointer, registered pop output and flags; FIFO_RD_UNDERFLOW_EN adds a sticky underflow flag
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int w_address = FIFO_W_ADDRESS,
    parameter int w_data = 8,
    parameter int L_fifo = FIFO_L,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_address:0] write_pointer,
    input  logic [w_data-1:0]  READ_DATA,
    input  logic               rd_en,
    output logic [w_address:0] read_pointer,
    output logic [w_data-1:0]  rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               almost_empty,
`ifdef FIFO_RD_UNDERFLOW_EN
    output logic               underflow,
`endif
    output logic [w_address:0] rd_count
);
    logic [w_address:0] r_read_pointer;
    logic [w_data-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               w_empty;
    logic               w_pop;

    if (!depth_ok(w_address, L_fifo) || !FIFO_DEPTH_OK) begin : g_depth_check
        $error("L_fifo must equal 2**w_address");
    end

    fifo_rd_flags #(
        .w_address(w_address),
        .AE_THRESH(AE_THRESH)
    ) u_flags (
        .read_pointer (r_read_pointer),
        .write_pointer(write_pointer),
        .rd_count     (rd_count),
        .empty        (w_empty),
        .almost_empty (almost_empty)
    );

    assign w_pop = rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_pointer <= '0;
            r_rd_data <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_read_pointer <= r_read_pointer + 1'b1;
                r_rd_data <= READ_DATA;
            end
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic r_underflow;
    always_ff @(posedge clk) begin
        if (rst) r_underflow <= 1'b0;
        else if (rd_en && w_empty) r_underflow <= 1'b1;
    end
    assign underflow = r_underflow;
`endif

    assign read_pointer = r_read_pointer;
    assign rd_data = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty = w_empty;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed and random pops against a queue-level FIFO model
module tb_fifo_read_ctrl;
    import fifo_pkg::*;
    logic clk = 1'b0;
    logic rst, rd_en;
    fifo_ptr_t write_pointer, read_pointer, rd_count;
    logic [7:0] READ_DATA, rd_data;
    logic rd_valid, empty, almost_empty;
`ifdef FIFO_RD_UNDERFLOW_EN
    logic underflow;
`endif
    logic [7:0] mem [16];
    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    int m_rp = 0;
    logic [7:0] m_data = 0;
    bit m_valid = 0, m_uf = 0;

    fifo_read_ctrl dut (
        .clk(clk), .rst(rst), .write_pointer(write_pointer), .READ_DATA(READ_DATA),
        .rd_en(rd_en), .read_pointer(read_pointer), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .almost_empty(almost_empty),
`ifdef FIFO_RD_UNDERFLOW_EN
        .underflow(underflow),
`endif
        .rd_count(rd_count)
    );

    assign READ_DATA = mem[read_pointer[3:0]];
    always #5 clk = ~clk;

    function automatic int m_count();
        return (int'(write_pointer) - m_rp) & 31;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("read_pointer", 32'(read_pointer), m_rp);
        chk("rd_data", 32'(rd_data), 32'(m_data));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_count", 32'(rd_count), m_count());
        chk("empty", 32'(empty), 32'(m_count() == 0));
        chk("almost_empty", 32'(almost_empty), 32'(m_count() <= 2));
`ifdef FIFO_RD_UNDERFLOW_EN
        chk("underflow", 32'(underflow), 32'(m_uf));
`endif
    end

    task automatic step(input bit r, input bit re, input bit we, input logic [7:0] d);
        int nrp;
        logic [7:0] nd;
        bit pop, nuf;
        rst = r;
        rd_en = re;
        pop = !r && re && m_count() != 0;
        nrp = r ? 0 : pop ? (m_rp + 1) % 32 : m_rp;
        nd = r ? 8'h00 : pop ? mem[m_rp % 16] : m_data;
        nuf = !r && (m_uf || (re && m_count() == 0));
        @(posedge clk);
        #1;
        m_rp = nrp;
        m_data = nd;
        m_valid = pop;
        m_uf = nuf;
        if (r) write_pointer = '0;
        else if (we) begin
            mem[write_pointer[3:0]] = d;
            write_pointer = write_pointer + 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 1);
        write_pointer = '0;
        rst = 1'b1;
        rd_en = 1'b0;
        step(1, 0, 0, 0);
        chk_en = 1;
        step(1, 0, 0, 0);
        chk("reset_rp", 32'(read_pointer), 0);
        chk("reset_valid", 32'(rd_valid), 0);
        chk("reset_data", 32'(rd_data), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_ae", 32'(almost_empty), 1);
        chk("reset_count", 32'(rd_count), 0);
        step(0, 0, 1, 8'h11);
        step(0, 0, 1, 8'h22);
        step(0, 0, 1, 8'h33);
        chk("drain_count", 32'(rd_count), 3);
        step(0, 1, 0, 0);
        chk("drain_d0", 32'(rd_data), 32'h11);
        chk("drain_v0", 32'(rd_valid), 1);
        step(0, 1, 0, 0);
        chk("drain_d1", 32'(rd_data), 32'h22);
        step(0, 1, 0, 0);
        chk("drain_d2", 32'(rd_data), 32'h33);
        chk("drain_v2", 32'(rd_valid), 1);
        step(0, 1, 0, 0);
        chk("drain_v3", 32'(rd_valid), 0);
        chk("drain_rp", 32'(read_pointer), 3);
        chk("drain_empty", 32'(empty), 1);
        write_pointer = 5'd15;
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
        chk("wrap_pre_rp", 32'(read_pointer), 15);
        mem[15] = 8'hA5;
        mem[0] = 8'h5A;
        write_pointer = 5'd17;
        step(0, 1, 0, 0);
        chk("wrap_rp16", 32'(read_pointer), 16);
        chk("wrap_d15", 32'(rd_data), 32'hA5);
        step(0, 1, 0, 0);
        chk("wrap_rp17", 32'(read_pointer), 17);
        chk("wrap_d0", 32'(rd_data), 32'h5A);
        chk("wrap_empty", 32'(empty), 1);
        step(1, 0, 0, 0);
        write_pointer = 5'd16;
        step(0, 0, 0, 0);
        chk("full_count", 32'(rd_count), 16);
        chk("full_empty", 32'(empty), 0);
        step(0, 1, 0, 0);
        chk("full_pop_count", 32'(rd_count), 15);
        step(1, 0, 0, 0);
        step(0, 1, 1, 8'hC3);
        chk("uf_rp", 32'(read_pointer), 0);
        chk("uf_valid", 32'(rd_valid), 0);
`ifdef FIFO_RD_UNDERFLOW_EN
        chk("uf_flag", 32'(underflow), 1);
`endif
        step(0, 1, 0, 0);
        chk("uf_next_data", 32'(rd_data), 32'hC3);
        chk("uf_next_valid", 32'(rd_valid), 1);
        write_pointer = 5'd6;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("mid_rst_rp", 32'(read_pointer), 0);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_data", 32'(rd_data), 0);
        for (int i = 0; i < 600; i++) begin
            bit r, re, we;
            r = $urandom_range(0, 99) == 0;
            re = $urandom_range(0, 2) != 0;
            we = !r && m_count() < 16 && $urandom_range(0, 1) == 1;
            step(r, re, we, 8'($urandom));
        end
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
